// File: rtl/key_debounce_pkg.sv
// Shared constants, event byte type and event encoding for the key debouncer.
package key_debounce_pkg;

  localparam int DEF_NUM_KEYS     = 4;
  localparam int DEF_STABLE_TICKS = 3;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef logic [7:0] evt_byte_t;

  localparam evt_byte_t EVT_PRESS_BASE   = 8'h41;
  localparam evt_byte_t EVT_RELEASE_BASE = 8'h61;

  typedef enum logic {
    EVT_RELEASE = 1'b0,
    EVT_PRESS   = 1'b1
  } evt_dir_t;

  // Uppercase letter for a press, lowercase for a release, offset by key index.
  function automatic evt_byte_t evt_code(input evt_dir_t dir, input logic [4:0] idx);
    return (dir == EVT_PRESS) ? EVT_PRESS_BASE + evt_byte_t'(idx)
                              : EVT_RELEASE_BASE + evt_byte_t'(idx);
  endfunction

endpackage

// File: rtl/key_debounce_fifo.sv
// First-word-fall-through event queue with count-based full/empty flags.
module evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push is refused while full even if the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_debounce.sv
// Tick-based key debouncer that queues ASCII press/release events for a UART.
// Define KEY_DEBOUNCE_INVERT_EN for active-low buttons (inputs inverted before sync).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS     = DEF_NUM_KEYS,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Tick,
  input  logic [NUM_KEYS-1:0] Keys_In,
  output logic [NUM_KEYS-1:0] Keys_Level,
  output logic [7:0]          Evt_Data,
  output logic                Evt_Valid,
  input  logic                Evt_Ready,
  output logic                Overflow
);

  localparam int            CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] qualify;
  logic [NUM_KEYS-1:0] push_mask;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [4:0]          sel;
  logic                sel_dir;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  evt_byte_t           push_data;

`ifdef KEY_DEBOUNCE_INVERT_EN
  assign raw = ~Keys_In;
`else
  assign raw = Keys_In;
`endif

  always_comb begin
    qualify = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      qualify[i] = Tick && (sync2[i] != Keys_Level[i]) && (cnt[i] == CNT_LAST);
  end

  // Descending scan so the lowest pending index wins.
  always_comb begin
    sel     = '0;
    sel_dir = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel     = 5'(i);
        sel_dir = Keys_Level[i];
      end
    end
  end

  assign push      = (|pending) && !fifo_full;
  assign push_mask = push ? (NUM_KEYS'(1) << sel) : '0;
  assign push_data = evt_code(evt_dir_t'(sel_dir), sel);
  assign Evt_Valid = !fifo_empty;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync1      <= '0;
      sync2      <= '0;
      Keys_Level <= '0;
      pending    <= '0;
      Overflow   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == Keys_Level[i]) begin
          cnt[i] <= '0;
        end else if (Tick) begin
          if (cnt[i] == CNT_LAST) begin
            cnt[i]        <= '0;
            Keys_Level[i] <= sync2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
      pending <= (pending & ~push_mask) | qualify;
      // Re-qualifying a key whose previous event is still waiting loses one event.
      if (|(pending & ~push_mask & qualify)) Overflow <= 1'b1;
    end
  end

  evt_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (Evt_Valid && Evt_Ready),
    .head      (Evt_Data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
